dadda_reduce_pipe: RTL and testbench

// - Front end of the 16x16 Dadda multiplier: partial-product generation plus Dadda column reduction down to two 32-bit rows.
// - Registered, two-stage pipeline with valid/ready handshake.
// - Feeds the 32-bit Brent-Kung final adder: row_s -> a, row_c -> b, cin tied 0, cout ignored.
// - Invariant: row_s + row_c == a*b mod 2^32.

---
 rtl/dadda_reduce_pipe.sv | 161 ++++++++++++++++
 tb/tb_dadda_reduce_pipe.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/dadda_reduce_pipe.sv
// 16x16 Dadda partial-product reduction to two 32-bit rows, two-stage valid/ready pipeline.
// Optional Baugh-Wooley signed mode is enabled with `define DADDA_SIGNED_EN.
module dadda_reduce_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
`ifdef DADDA_SIGNED_EN
  input  logic        signed_mode,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] row_s,
  output logic [31:0] row_c,
  output logic [1:0]  inflight
);

  // Bit matrix: m[column][slot], h[column] = number of live slots in that column.
  typedef struct packed {
    logic [31:0][15:0] m;
    logic [31:0][4:0]  h;
  } mat_t;

  function automatic mat_t gen(input logic [15:0] x, input logic [15:0] y, input logic sm);
    mat_t r;
    logic bitv;
    int   c;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        c    = i + j;
        bitv = x[j] & y[i];
        if (sm && ((i == 15) != (j == 15))) bitv = ~bitv;
        r.m[c[4:0]][r.h[c[4:0]][3:0]] = bitv;
        r.h[c[4:0]] = r.h[c[4:0]] + 5'd1;
      end
    end
`ifdef DADDA_SIGNED_EN
    r.m[16][r.h[16][3:0]] = sm;
    r.h[16] = r.h[16] + 5'd1;
    r.m[31][r.h[31][3:0]] = sm;
    r.h[31] = r.h[31] + 5'd1;
`endif
    return r;
  endfunction

  // One Dadda level: each column is trimmed to height t counting the carries it
  // receives from the column below; FAs first, an HA only for a remaining excess of 1.
  function automatic mat_t step(input mat_t x, input int t);
    mat_t        y;
    logic [15:0] src, sh, col, carries, ncar;
    logic        b0, b1, b2;
    int          n, k, o, nc, cin, need;
    y       = '0;
    carries = '0;
    cin     = 0;
    for (int c = 0; c < 32; c++) begin
      src  = x.m[c[4:0]];
      n    = int'(x.h[c[4:0]]);
      need = n + cin - t;
      k    = 0;
      o    = 0;
      nc   = 0;
      col  = '0;
      ncar = '0;
      for (int q = 0; q < 16; q++) begin
        sh = src >> k;
        b0 = sh[0];
        b1 = sh[1];
        b2 = sh[2];
        if (need >= 2 && k + 3 <= n) begin
          col[o[3:0]]   = b0 ^ b1 ^ b2;
          ncar[nc[3:0]] = (b0 & b1) | (b0 & b2) | (b1 & b2);
          o = o + 1; nc = nc + 1; k = k + 3; need = need - 2;
        end else if (need >= 1 && k + 2 <= n) begin
          col[o[3:0]]   = b0 ^ b1;
          ncar[nc[3:0]] = b0 & b1;
          o = o + 1; nc = nc + 1; k = k + 2; need = need - 1;
        end
      end
      sh = src >> k;
      for (int r = 0; r < 16; r++) begin
        if (r < n - k) begin
          col[o[3:0]] = sh[r[3:0]];
          o = o + 1;
        end
      end
      for (int r = 0; r < 16; r++) begin
        if (r < cin) begin
          col[o[3:0]] = carries[r[3:0]];
          o = o + 1;
        end
      end
      y.m[c[4:0]] = col;
      y.h[c[4:0]] = o[4:0];
      carries     = ncar;
      cin         = nc;
    end
    return y;
  endfunction

  logic              v1, v2, s1_adv, s2_adv, mode_in;
  logic [31:0][5:0]  s1_m, s1_d;
  logic [31:0]       rs_d, rc_d;

`ifdef DADDA_SIGNED_EN
  assign mode_in = signed_mode;
`else
  assign mode_in = 1'b0;
`endif

  assign s2_adv    = !v2 || out_ready;
  assign s1_adv    = !v1 || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = v2;
  assign inflight  = {1'b0, v1} + {1'b0, v2};

  always_comb begin
    mat_t ma;
    ma = step(step(step(gen(a, b, mode_in), 13), 9), 6);
    s1_d = '0;
    for (int c = 0; c < 32; c++) s1_d[c[4:0]] = ma.m[c[4:0]][5:0];
  end

  // Column heights are data-independent, so stage 2 rebuilds them from an all-zero matrix.
  always_comb begin
    mat_t hm, mb;
    hm   = step(step(step(gen(16'h0, 16'h0, 1'b0), 13), 9), 6);
    mb   = '0;
    mb.h = hm.h;
    for (int c = 0; c < 32; c++) mb.m[c[4:0]][5:0] = s1_m[c[4:0]];
    mb = step(step(step(mb, 4), 3), 2);
    rs_d = '0;
    rc_d = '0;
    for (int c = 0; c < 32; c++) begin
      if (mb.h[c[4:0]] >= 5'd1) rs_d[c[4:0]] = mb.m[c[4:0]][0];
      if (mb.h[c[4:0]] >= 5'd2) rc_d[c[4:0]] = mb.m[c[4:0]][1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      s1_m  <= '0;
      row_s <= '0;
      row_c <= '0;
    end else begin
      if (s1_adv) v1 <= in_valid;
      if (s1_adv && in_valid) s1_m <= s1_d;
      if (s2_adv) v2 <= v1;
      if (s2_adv && v1) begin
        row_s <= rs_d;
        row_c <= rc_d;
      end
    end
  end

endmodule

// File: tb/tb_dadda_reduce_pipe.sv
// Scoreboard bench for dadda_reduce_pipe: expected products queued on accept, compared on output.
module tb_dadda_reduce_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        sm = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] row_s, row_c;
  logic [1:0]  inflight;

  int          npass = 0;
  int          ntotal = 0;
  logic [31:0] sb[$];
  logic [31:0] rs0, rc0;

  always #5 clk = ~clk;

  dadda_reduce_pipe dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
`ifdef DADDA_SIGNED_EN
    .signed_mode(sm),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .row_s(row_s),
    .row_c(row_c),
    .inflight(inflight)
  );

  function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y, input logic s);
    logic signed [31:0] p;
    if (s) p = $signed(x) * $signed(y);
    else   p = {16'h0, x} * {16'h0, y};
    return p;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Evaluate handshake for the coming edge, advance one clock, settle 1 ns past the edge.
  task automatic step();
    logic [31:0] e;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) check("unexpected_output", 32'(out_valid), 32'd0);
      else begin
        e = sb.pop_front();
        check("sum", row_s + row_c, e);
        check("row_c0", 32'(row_c[0]), 32'd0);
      end
    end
    if (in_valid && in_ready) sb.push_back(model(a, b, sm));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int maxc);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < maxc && sb.size() > 0; i++) step();
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_inflight", 32'(inflight), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_row_s", row_s, 32'd0);
    check("rst_row_c", row_c, 32'd0);

    // Single op latency
    a = 16'hFFFF; b = 16'hFFFF; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("lat_edge1_valid", 32'(out_valid), 32'd0);
    step();
    check("lat_edge2_valid", 32'(out_valid), 32'd1);
    check("lat_ffff_sum", row_s + row_c, 32'hFFFE0001);
    drain(10);

    // Zero / identity
    a = 16'h0000; b = 16'h1234; in_valid = 1'b1;
    step();
    a = 16'h0001; b = 16'hBEEF;
    step();
    drain(10);

    // Back-to-back streaming
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      if (i >= 2) check("stream_no_gap", 32'(out_valid), 32'd1);
      step();
    end
    drain(10);

    // Backpressure
    out_ready = 1'b0; in_valid = 1'b1;
    a = 16'h1357; b = 16'h2468; step();
    a = 16'hA5A5; b = 16'h5A5A; step();
    a = 16'h7FFF; b = 16'h0003;
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_inflight", 32'(inflight), 32'd2);
    check("bp_queue", 32'(sb.size()), 32'd2);
    rs0 = row_s; rc0 = row_c;
    step(); step();
    check("bp_row_s_stable", row_s, rs0);
    check("bp_row_c_stable", row_c, rc0);
    check("bp_still_full", 32'(inflight), 32'd2);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("bp_drain_valid1", 32'(out_valid), 32'd1);
    step();
    check("bp_drain_valid2", 32'(out_valid), 32'd1);
    drain(10);

    // Mid-operation reset with pipeline full
    out_ready = 1'b0; in_valid = 1'b1;
    a = 16'h4321; b = 16'h8765; step();
    a = 16'h0F0F; b = 16'hF0F0; step();
    check("mr_inflight_full", 32'(inflight), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check("mr_inflight", 32'(inflight), 32'd0);
    check("mr_row_s", row_s, 32'd0);
    sb.delete();
    in_valid = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mr_in_ready", 32'(in_ready), 32'd1);
    a = 16'hCAFE; b = 16'h0101; in_valid = 1'b1; out_ready = 1'b1;
    step();
    drain(10);

`ifdef DADDA_SIGNED_EN
    sm = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    a = 16'hFFFF; b = 16'h0002; step();
    check("sgn_model_m1x2", model(a, b, sm), 32'hFFFFFFFE);
    a = 16'h8000; b = 16'h8000; step();
    for (int i = 0; i < 20; i++) begin
      a = 16'($urandom); b = 16'($urandom); sm = 1'($urandom);
      step();
    end
    drain(10);
    sm = 1'b0;
`endif

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
